voice_allocator: RTL and testbench

- Polyphony controller that assigns incoming note-on/note-off events to a bank of NUM_VOICES detuned oscillator voices.
- Drives each voice's frequency word, gate and phase-reset, and broadcasts the shared waveform select and detune configuration.
- Sits between the note/keyboard front end (which supplies the note number and the Hz frequency word) and the oscillator bank feeding the envelope/mixer stage.
- Steals the oldest sounding voice when all voices are busy.

---
 rtl/voice_allocator.sv | 255 +++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Polyphony controller. Assigns note-on/note-off events to a bank
//            of NUM_VOICES oscillator voices, stealing the oldest sounding
//            voice when every voice is busy. Drives per-voice frequency, gate
//            and phase-reset, and broadcasts the shared waveform/detune.
// Ports    : clk, reset (async, active low)
//            note_valid/note_ready    - event handshake
//            note_on/note_num/note_freq - event payload (latched on accept)
//            cfg_we/cfg_ctrl/cfg_detune - shared oscillator configuration
//            voice_freq/voice_gate/voice_reset - per-voice outputs
//            voice_ctrl/voice_detune  - registered shared configuration
//            steal_pulse              - one-cycle pulse on a voice steal
//            active_count             - number of gated voices
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       note_valid,
  output logic                       note_ready,
  input  logic                       note_on,
  input  logic [6:0]                 note_num,
  input  logic [19:0]                note_freq,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_ctrl,
  input  logic [3:0]                 cfg_detune,
  output logic [20*NUM_VOICES-1:0]   voice_freq,
  output logic [NUM_VOICES-1:0]      voice_gate,
  output logic [NUM_VOICES-1:0]      voice_reset,
  output logic [1:0]                 voice_ctrl,
  output logic [3:0]                 voice_detune,
  output logic                       steal_pulse,
  output logic [4:0]                 active_count
);

  localparam int                IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0]  c_AGE_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       w_accept;
  logic                       r_ready;
  logic [IDX_W-1:0]           r_idx;

  // Latched event payload
  logic                       r_lat_on;
  logic [6:0]                 r_lat_num;
  logic [19:0]                r_lat_freq;

  // Per-voice state
  logic [6:0]                 r_note [NUM_VOICES];
  logic [AGE_W-1:0]           r_age  [NUM_VOICES];
  logic [20*NUM_VOICES-1:0]   r_freq;
  logic [NUM_VOICES-1:0]      r_gate;
  logic [NUM_VOICES-1:0]      r_voice_reset;
  logic                       r_steal;
  logic [1:0]                 r_ctrl;
  logic [3:0]                 r_detune;
  logic [4:0]                 r_active_count;

  // Scan results
  logic                       r_match_found;
  logic [IDX_W-1:0]           r_match_idx;
  logic                       r_free_found;
  logic [IDX_W-1:0]           r_free_idx;
  logic                       r_old_found;
  logic [IDX_W-1:0]           r_old_idx;
  logic [AGE_W-1:0]           r_old_age;

  logic [IDX_W-1:0]           w_target;
  logic                       w_steal;
  logic [NUM_VOICES-1:0]      w_gate_next;
  logic [4:0]                 w_gate_count;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (note_valid && r_ready) begin
          w_accept     = 1'b1;
          w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Commit target selection and next gate vector. A retrigger (match) wins
  // over a free voice, which wins over stealing the oldest.
  // --------------------------------------------------------------------------
  always_comb begin
    w_target = r_old_idx;
    if (r_match_found) begin
      w_target = r_match_idx;
    end else if (r_free_found) begin
      w_target = r_free_idx;
    end
    w_steal = !r_match_found && !r_free_found;

    w_gate_next = r_gate;
    if (r_state == ST_COMMIT) begin
      if (r_lat_on) begin
        w_gate_next[w_target] = 1'b1;
      end else if (r_match_found) begin
        w_gate_next[r_match_idx] = 1'b0;
      end
    end

    w_gate_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_gate_count = w_gate_count + 5'(w_gate_next[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready        <= 1'b0;
      r_idx          <= '0;
      r_lat_on       <= 1'b0;
      r_lat_num      <= '0;
      r_lat_freq     <= '0;
      r_freq         <= '0;
      r_gate         <= '0;
      r_voice_reset  <= '0;
      r_steal        <= 1'b0;
      r_ctrl         <= '0;
      r_detune       <= '0;
      r_active_count <= '0;
      r_match_found  <= 1'b0;
      r_match_idx    <= '0;
      r_free_found   <= 1'b0;
      r_free_idx     <= '0;
      r_old_found    <= 1'b0;
      r_old_idx      <= '0;
      r_old_age      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      // Ready mirrors "IDLE next cycle", which also holds it low for the
      // first edge after reset release.
      r_ready        <= (w_state_next == ST_IDLE);
      r_voice_reset  <= '0;
      r_steal        <= 1'b0;
      r_gate         <= w_gate_next;
      r_active_count <= w_gate_count;

      if (cfg_we) begin
        r_ctrl   <= cfg_ctrl;
        r_detune <= cfg_detune;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_lat_on      <= note_on;
            r_lat_num     <= note_num;
            r_lat_freq    <= note_freq;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_old_found   <= 1'b0;
          end
        end

        ST_SCAN: begin
          if (!r_match_found && r_gate[r_idx] && (r_note[r_idx] == r_lat_num)) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!r_free_found && !r_gate[r_idx]) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          // Strictly greater keeps the lowest index on an age tie.
          if (r_gate[r_idx] && (!r_old_found || (r_age[r_idx] > r_old_age))) begin
            r_old_found <= 1'b1;
            r_old_idx   <= r_idx;
            r_old_age   <= r_age[r_idx];
          end
          if (r_idx != c_LAST_IDX) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        ST_COMMIT: begin
          if (r_lat_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (w_target == IDX_W'(i)) begin
                r_freq[20*i +: 20] <= r_lat_freq;
                r_note[i]          <= r_lat_num;
                r_age[i]           <= '0;
              end else if (r_gate[i] && (r_age[i] != c_AGE_MAX)) begin
                r_age[i] <= r_age[i] + AGE_W'(1);
              end
            end
            r_voice_reset <= NUM_VOICES'(1) << w_target;
            r_steal       <= w_steal;
          end
        end

        default: ;
      endcase
    end
  end

  assign note_ready   = r_ready;
  assign voice_freq   = r_freq;
  assign voice_gate   = r_gate;
  assign voice_reset  = r_voice_reset;
  assign voice_ctrl   = r_ctrl;
  assign voice_detune = r_detune;
  assign steal_pulse  = r_steal;
  assign active_count = r_active_count;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Self-checking bench for voice_allocator with directed scenarios
//            and randomized events checked against a behavioural voice model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

  localparam int NV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             note_valid;
  logic             note_ready;
  logic             note_on;
  logic [6:0]       note_num;
  logic [19:0]      note_freq;
  logic             cfg_we;
  logic [1:0]       cfg_ctrl;
  logic [3:0]       cfg_detune;
  logic [20*NV-1:0] voice_freq;
  logic [NV-1:0]    voice_gate;
  logic [NV-1:0]    voice_reset;
  logic [1:0]       voice_ctrl;
  logic [3:0]       voice_detune;
  logic             steal_pulse;
  logic [4:0]       active_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the voice bank
  int m_gate [NV];
  int m_note [NV];
  int m_freq [NV];
  int m_age  [NV];

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .note_on      (note_on),
    .note_num     (note_num),
    .note_freq    (note_freq),
    .cfg_we       (cfg_we),
    .cfg_ctrl     (cfg_ctrl),
    .cfg_detune   (cfg_detune),
    .voice_freq   (voice_freq),
    .voice_gate   (voice_gate),
    .voice_reset  (voice_reset),
    .voice_ctrl   (voice_ctrl),
    .voice_detune (voice_detune),
    .steal_pulse  (steal_pulse),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Model helpers
  // --------------------------------------------------------------------------
  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_freq[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_event(input bit on, input int num, input int freq,
                             output int tgt, output bit steal);
    int match = -1;
    int free  = -1;
    int old   = -1;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_gate[i] != 0 && m_note[i] == num) match = i;
      if (free < 0 && m_gate[i] == 0) free = i;
      if (m_gate[i] != 0 && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    tgt   = -1;
    steal = 1'b0;
    if (on) begin
      tgt   = (match >= 0) ? match : ((free >= 0) ? free : old);
      steal = (match < 0) && (free < 0);
      for (int i = 0; i < NV; i++) begin
        if (i != tgt && m_gate[i] != 0 && m_age[i] < 255) m_age[i]++;
      end
      m_gate[tgt] = 1; m_note[tgt] = num; m_freq[tgt] = freq; m_age[tgt] = 0;
    end else if (match >= 0) begin
      m_gate[match] = 0;
    end
  endtask

  function automatic logic [20*NV-1:0] m_freq_vec();
    logic [20*NV-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[20*i +: 20] = 20'(m_freq[i]);
    return v;
  endfunction

  function automatic logic [NV-1:0] m_gate_vec();
    logic [NV-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = (m_gate[i] != 0);
    return v;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NV; i++) c += (m_gate[i] != 0) ? 1 : 0;
    return c;
  endfunction

  // Drive one event, wait for acceptance, then advance to just after the
  // commit edge (accept edge + NV + 1). Inputs are scrambled after accept.
  task automatic run_event(input bit on, input int num, input int freq,
                           output int tgt, output bit steal);
    int cyc = 0;
    tgt   = -1;
    steal = 1'b0;
    @(negedge clk);
    note_valid = 1'b1; note_on = on; note_num = 7'(num); note_freq = 20'(freq);
    while (!note_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!note_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: note_ready=%0b after %0d cycles, required 1", note_ready, cyc);
      note_valid = 1'b0;
      return;
    end
    model_event(on, num, freq, tgt, steal);
    @(posedge clk); #1;
    note_valid = 1'b0;
    note_on    = 1'($urandom);
    note_num   = 7'($urandom);
    note_freq  = 20'($urandom);
    repeat (NV + 1) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; note_valid = 1'b0; note_on = 1'b0; note_num = '0; note_freq = '0;
    cfg_we = 1'b0; cfg_ctrl = '0; cfg_detune = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({voice_freq, voice_gate, voice_reset, voice_ctrl, voice_detune, steal_pulse, active_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gate=%b freq=%h rst=%b active=%0d, required all 0", voice_gate, voice_freq, voice_reset, active_count);
    end
    n_checks++;
    if (note_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b required 0", note_ready);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (note_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b required 1", note_ready);
    end
    model_clear();
  endtask

  task automatic test_config();
    logic [1:0] ec;
    logic [3:0] ed;
    for (int k = 0; k < 4; k++) begin
      ec = 2'($urandom); ed = 4'($urandom);
      @(negedge clk); cfg_we = 1'b1; cfg_ctrl = ec; cfg_detune = ed;
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_ctrl = ~ec; cfg_detune = ~ed;
      n_checks++;
      if (voice_ctrl !== ec || voice_detune !== ed) begin
        n_fail++; $display("FAIL cfg_load: got %b/%h required %b/%h", voice_ctrl, voice_detune, ec, ed);
      end
      @(posedge clk); #1;
      n_checks++;
      if (voice_ctrl !== ec || voice_detune !== ed) begin
        n_fail++; $display("FAIL cfg_hold: got %b/%h required %b/%h", voice_ctrl, voice_detune, ec, ed);
      end
    end
  endtask

  task automatic test_first_note();
    int tgt; bit st;
    run_event(1'b1, 60, 262, tgt, st);
    n_checks++;
    if (voice_gate !== 4'b0001 || voice_freq[19:0] !== 20'd262) begin
      n_fail++; $display("FAIL first_note: got gate=%b f0=%0d required 0001/262", voice_gate, voice_freq[19:0]);
    end
    n_checks++;
    if (voice_reset !== 4'b0001 || steal_pulse !== 1'b0 || active_count !== 5'd1 || note_ready !== 1'b1) begin
      n_fail++; $display("FAIL first_note_ctrl: got rst=%b steal=%b act=%0d rdy=%b required 0001/0/1/1", voice_reset, steal_pulse, active_count, note_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (voice_reset !== 4'b0000) begin
      n_fail++; $display("FAIL first_note_pulse: got rst=%b required 0000", voice_reset);
    end
  endtask

  task automatic test_back_to_back();
    int nums [3] = '{64, 67, 72};
    int frqs [3] = '{330, 392, 523};
    int acc  [3] = '{0, 0, 0};
    int cyc = 0;
    int k   = 0;
    int tgt;
    bit st;
    bit acc_now;
    @(negedge clk);
    note_valid = 1'b1; note_on = 1'b1; note_num = 7'(nums[0]); note_freq = 20'(frqs[0]);
    while (k < 3 && cyc < 100) begin
      acc_now = note_ready;
      if (acc_now) begin
        acc[k] = cyc;
        model_event(1'b1, nums[k], frqs[k], tgt, st);
        k++;
      end
      @(posedge clk); cyc++; #1;
      if (acc_now) begin
        if (k < 3) begin
          note_num = 7'(nums[k]); note_freq = 20'(frqs[k]);
        end else begin
          note_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    note_valid = 1'b0;
    n_checks++;
    if (k != 3) begin
      n_fail++; $display("FAIL b2b_accept: got %0d accepts required 3", k);
    end
    n_checks++;
    if (acc[1] - acc[0] != NV + 2 || acc[2] - acc[1] != NV + 2) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d,%0d required %0d", acc[1] - acc[0], acc[2] - acc[1], NV + 2);
    end
    repeat (NV + 1) @(posedge clk);
    #1;
    n_checks++;
    if (voice_gate !== 4'b1111 || voice_freq !== {20'd523, 20'd392, 20'd330, 20'd262} || active_count !== 5'd4) begin
      n_fail++; $display("FAIL b2b_result: got gate=%b freq=%h act=%0d required 1111/523,392,330,262/4", voice_gate, voice_freq, active_count);
    end
  endtask

  task automatic test_steal();
    int tgt; bit st;
    run_event(1'b1, 76, 659, tgt, st);
    n_checks++;
    if (voice_freq[19:0] !== 20'd659 || steal_pulse !== 1'b1 || voice_reset !== 4'b0001 || active_count !== 5'd4) begin
      n_fail++; $display("FAIL steal: got f0=%0d steal=%b rst=%b act=%0d required 659/1/0001/4", voice_freq[19:0], steal_pulse, voice_reset, active_count);
    end
    @(posedge clk); #1;
    n_checks++;
    if (steal_pulse !== 1'b0) begin
      n_fail++; $display("FAIL steal_pulse_width: got %b required 0", steal_pulse);
    end
  endtask

  task automatic test_note_off();
    int tgt; bit st;
    logic [20*NV-1:0] f_snap;
    logic [NV-1:0]    g_snap;
    run_event(1'b0, 64, 0, tgt, st);
    n_checks++;
    if (voice_gate !== 4'b1101 || voice_freq[39:20] !== 20'd330 || voice_reset !== 4'b0000 || active_count !== 5'd3) begin
      n_fail++; $display("FAIL note_off: got gate=%b f1=%0d rst=%b act=%0d required 1101/330/0000/3", voice_gate, voice_freq[39:20], voice_reset, active_count);
    end
    f_snap = voice_freq; g_snap = voice_gate;
    run_event(1'b0, 50, 0, tgt, st);
    n_checks++;
    if (voice_gate !== g_snap || voice_freq !== f_snap || active_count !== 5'd3 || voice_reset !== 4'b0000) begin
      n_fail++; $display("FAIL off_unknown: got gate=%b act=%0d required %b/3", voice_gate, active_count, g_snap);
    end
    run_event(1'b1, 79, 784, tgt, st);
    n_checks++;
    if (voice_gate !== 4'b1111 || voice_freq[39:20] !== 20'd784 || voice_reset !== 4'b0010 || steal_pulse !== 1'b0) begin
      n_fail++; $display("FAIL refill_free: got gate=%b f1=%0d rst=%b steal=%b required 1111/784/0010/0", voice_gate, voice_freq[39:20], voice_reset, steal_pulse);
    end
  endtask

  task automatic test_retrigger();
    int tgt; bit st;
    run_event(1'b1, 67, 392, tgt, st);
    n_checks++;
    if (voice_reset !== 4'b0100 || voice_gate !== 4'b1111 || steal_pulse !== 1'b0 || voice_freq[59:40] !== 20'd392) begin
      n_fail++; $display("FAIL retrigger: got rst=%b gate=%b steal=%b required 0100/1111/0", voice_reset, voice_gate, steal_pulse);
    end
  endtask

  task automatic test_random();
    int tgt; bit st;
    bit on;
    int num, freq;
    logic [NV-1:0] exp_rst;
    for (int k = 0; k < 60; k++) begin
      on   = ($urandom_range(0, 9) < 7);
      num  = 40 + $urandom_range(0, 5);
      freq = $urandom_range(0, 20'hFFFFF);
      run_event(on, num, freq, tgt, st);
      exp_rst = (tgt >= 0) ? NV'(1) << tgt : '0;
      n_checks++;
      if (voice_gate !== m_gate_vec() || voice_freq !== m_freq_vec()) begin
        n_fail++; $display("FAIL rand_voices[%0d]: got gate=%b freq=%h required %b/%h", k, voice_gate, voice_freq, m_gate_vec(), m_freq_vec());
      end
      n_checks++;
      if (voice_reset !== exp_rst || steal_pulse !== st || active_count !== 5'(m_count())) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got rst=%b steal=%b act=%0d required %b/%b/%0d", k, voice_reset, steal_pulse, active_count, exp_rst, st, m_count());
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc = 0;
    @(negedge clk); cfg_we = 1'b1; cfg_ctrl = 2'b10; cfg_detune = 4'hA;
    @(negedge clk); cfg_we = 1'b0;
    note_valid = 1'b1; note_on = 1'b1; note_num = 7'd90; note_freq = 20'd1234;
    while (!note_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    note_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({voice_freq, voice_gate, voice_reset, voice_ctrl, voice_detune, steal_pulse, active_count, note_ready} !== '0) begin
      n_fail++; $display("FAIL async_reset: got gate=%b ctrl=%b rdy=%b act=%0d required all 0", voice_gate, voice_ctrl, note_ready, active_count);
    end
    @(negedge clk); reset = 1'b1;
    model_clear();
    @(posedge clk); #1;
    n_checks++;
    if (note_ready !== 1'b1 || voice_gate !== '0 || voice_freq !== '0 || voice_reset !== '0) begin
      n_fail++; $display("FAIL after_abort: got rdy=%b gate=%b freq=%h required 1/0/0", note_ready, voice_gate, voice_freq);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_first_note();
    test_back_to_back();
    test_steal();
    test_note_off();
    test_retrigger();
    test_random();
    test_reset_mid_scan();
    test_first_note();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
